// File: rtl/jtag_ocimem_pkg.sv
// Shared definitions for the JTAG on-chip-instruction-memory controller:
// state encoding, default geometry and jdo field positions.
package jtag_ocimem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StJrd  = 2'd1,
    StAvrd = 2'd2
  } ocimem_state_e;

  localparam int unsigned DefaultAddrW = 8;

  // jdo command word layout
  localparam int unsigned JdoReadBit   = 35;
  localparam int unsigned JdoDataHi    = 34;
  localparam int unsigned JdoDataLo    = 3;
  localparam int unsigned JdoAddrLo    = 26;
  localparam int unsigned JdoErrClrBit = 25;

endpackage

// File: rtl/jtag_ocimem_ram.sv
// Single-port debug monitor RAM: byte-enable write, registered read (1-cycle latency).
module jtag_ocimem_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/jtag_ocimem_ctrl.sv
// JTAG debug monitor RAM controller: arbitrates one RAM port between JTAG
// debug commands and a CPU-side Avalon-MM slave, JTAG always winning.
module jtag_ocimem_ctrl
  import jtag_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W-1:0] AddrOne = 1;

  ocimem_state_e     state;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [31:0]       readdata_q;

  logic              jtag_act;
  logic [ADDR_W-1:0] jdo_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              unused_jdo;

  assign jtag_act   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign jdo_addr   = jdo[JdoAddrLo +: ADDR_W];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Read data is live from the RAM during the capture cycle, held afterwards.
  assign avs_readdata = (state == StAvrd) ? ram_rdata : readdata_q;

  always_comb begin
    avs_waitrequest = 1'b0;
    if (!reset) begin
      unique case (state)
        StIdle:  avs_waitrequest = avs_read | (avs_write & jtag_act);
        StJrd:   avs_waitrequest = avs_read | avs_write;
        StAvrd:  avs_waitrequest = avs_write & ~avs_read;
        default: avs_waitrequest = 1'b0;
      endcase
    end
  end

  always_comb begin
    ram_addr  = avs_address;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = avs_byteenable;
    ram_wdata = avs_writedata;
    if (state != StJrd) begin
      if (take_action_ocimem_a) begin
        ram_addr = jdo_addr;
        ram_re   = jdo[JdoReadBit];
      end else if (take_no_action_ocimem_a) begin
        ram_addr = mon_a_reg;
        ram_re   = 1'b1;
      end else if (take_action_ocimem_b) begin
        ram_addr  = mon_a_reg;
        ram_we    = 1'b1;
        ram_be    = 4'hf;
        ram_wdata = jdo[JdoDataHi:JdoDataLo];
      end else if (state == StIdle) begin
        ram_re = avs_read;
        ram_we = avs_write & ~avs_read;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      readdata_q    <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else if (state == StJrd) begin
      MonDReg       <= ram_rdata;
      mon_a_reg     <= mon_a_reg + AddrOne;
      monitor_ready <= 1'b1;
      state         <= StIdle;
      if (jtag_act) monitor_error <= 1'b1;
    end else begin
      if (state == StAvrd) readdata_q <= ram_rdata;
      state <= StIdle;
      if (take_action_ocimem_a) begin
        mon_a_reg     <= jdo_addr;
        monitor_ready <= 1'b0;
        if (jdo[JdoErrClrBit]) monitor_error <= 1'b0;
        if (jdo[JdoReadBit]) state <= StJrd;
      end else if (take_no_action_ocimem_a) begin
        monitor_ready <= 1'b0;
        state         <= StJrd;
      end else if (take_action_ocimem_b) begin
        mon_a_reg     <= mon_a_reg + AddrOne;
        monitor_ready <= 1'b1;
      end else if (state == StIdle && avs_read) begin
        state <= StAvrd;
      end
    end
  end

  jtag_ocimem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .re   (ram_re),
    .we   (ram_we),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_jtag_ocimem_ctrl.sv
// Directed bench for jtag_ocimem_ctrl with hand-computed expected values.
module tb_jtag_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] mon_d;
  logic        monitor_ready, monitor_error;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  jtag_ocimem_ctrl #(
    .ADDR_W(8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta_a),
    .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b   (ta_b),
    .avs_address            (avs_address),
    .avs_read               (avs_read),
    .avs_write              (avs_write),
    .avs_writedata          (avs_writedata),
    .avs_byteenable         (avs_byteenable),
    .avs_readdata           (avs_readdata),
    .avs_waitrequest        (avs_waitrequest),
    .MonDReg                (mon_d),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [37:0] jdo_addr(input logic rd, input logic [7:0] a, input logic clr);
    logic [37:0] v;
    v          = '0;
    v[35]      = rd;
    v[33:26]   = a;
    v[25]      = clr;
    return v;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic rd, input logic [7:0] a, input logic clr);
    ta_a = 1'b1;
    jdo  = jdo_addr(rd, a, clr);
    tick();
    ta_a = 1'b0;
  endtask

  initial begin
    reset = 1'b1; jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
    avs_address = '0; avs_read = 1'b1; avs_write = 0; avs_writedata = '0; avs_byteenable = 4'hf;
    #12;
    check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
    check("rst_mondreg", mon_d, 32'd0);
    check("rst_ready", {31'd0, monitor_ready}, 32'd0);
    check("rst_error", {31'd0, monitor_error}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_mona", {24'd0, dut.mon_a_reg}, 32'd0);
    avs_read = 1'b0;
    #4 reset = 1'b0;
    tick();

    // Address load without read
    pulse_a(1'b0, 8'h10, 1'b0);
    check("load_mona", {24'd0, dut.mon_a_reg}, 32'h10);
    check("load_ready", {31'd0, monitor_ready}, 32'd0);
    tick();
    check("load_noread", mon_d, 32'd0);

    // JTAG write then read-back
    ta_b = 1'b1; jdo = jdo_data(32'hDEADBEEF);
    tick();
    ta_b = 1'b0;
    check("wr_ready", {31'd0, monitor_ready}, 32'd1);
    check("wr_mona", {24'd0, dut.mon_a_reg}, 32'h11);
    pulse_a(1'b1, 8'h10, 1'b0);
    check("rd_issue_ready", {31'd0, monitor_ready}, 32'd0);
    tick();
    check("rd_mondreg", mon_d, 32'hDEADBEEF);
    check("rd_mona", {24'd0, dut.mon_a_reg}, 32'h11);
    check("rd_ready", {31'd0, monitor_ready}, 32'd1);

    // Address wrap
    pulse_a(1'b1, 8'hFF, 1'b0);
    tick();
    check("wrap_mona", {24'd0, dut.mon_a_reg}, 32'h00);

    // Avalon write 0x20, then contention with a JTAG write at 0x30
    avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'hA5A55A5A; avs_byteenable = 4'hf;
    #2 check("avwr_wait", {31'd0, avs_waitrequest}, 32'd0);
    tick();
    avs_write = 1'b0;
    pulse_a(1'b0, 8'h30, 1'b0);
    ta_b = 1'b1; jdo = jdo_data(32'h0BADF00D);
    avs_read = 1'b1; avs_address = 8'h20;
    #2 check("cont_wait0", {31'd0, avs_waitrequest}, 32'd1);
    tick();
    ta_b = 1'b0;
    #2 check("cont_wait1", {31'd0, avs_waitrequest}, 32'd1);
    tick();
    #2 check("cont_wait2", {31'd0, avs_waitrequest}, 32'd0);
    check("cont_data", avs_readdata, 32'hA5A55A5A);
    tick();
    avs_read = 1'b0;
    #2 check("cont_hold", avs_readdata, 32'hA5A55A5A);

    // Overrun during JRD, then error clear
    pulse_a(1'b1, 8'h30, 1'b0);
    tna_a = 1'b1;
    tick();
    tna_a = 1'b0;
    check("ovr_error", {31'd0, monitor_error}, 32'd1);
    check("ovr_mondreg", mon_d, 32'h0BADF00D);
    check("ovr_mona", {24'd0, dut.mon_a_reg}, 32'h31);
    pulse_a(1'b0, 8'h40, 1'b1);
    check("clr_error", {31'd0, monitor_error}, 32'd0);
    check("clr_mona", {24'd0, dut.mon_a_reg}, 32'h40);

    // Byte-lane write
    avs_write = 1'b1; avs_address = 8'h50; avs_writedata = 32'hFFFFFFFF; avs_byteenable = 4'hf;
    tick();
    avs_writedata = 32'h11223344; avs_byteenable = 4'b0010;
    #2 check("bw_wait", {31'd0, avs_waitrequest}, 32'd0);
    tick();
    avs_write = 1'b0; avs_byteenable = 4'hf;
    avs_read = 1'b1;
    tick();
    #2 check("bw_rd_wait", {31'd0, avs_waitrequest}, 32'd0);
    check("bw_rd_data", avs_readdata, 32'hFFFF33FF);
    tick();
    avs_read = 1'b0;

    // Avalon blocked during JRD
    pulse_a(1'b1, 8'h50, 1'b0);
    avs_write = 1'b1; avs_address = 8'h60; avs_writedata = 32'h77;
    #2 check("jrd_block", {31'd0, avs_waitrequest}, 32'd1);
    tick();
    check("jrd_mondreg", mon_d, 32'hFFFF33FF);
    #2 check("jrd_after", {31'd0, avs_waitrequest}, 32'd0);
    tick();
    avs_write = 1'b0;

    // Reset in JRD aborts; RAM retains contents
    pulse_a(1'b1, 8'h10, 1'b0);
    avs_read = 1'b1; avs_address = 8'h10;
    #2 reset = 1'b1;
    #1 check("rstjrd_wait", {31'd0, avs_waitrequest}, 32'd0);
    check("rstjrd_mondreg", mon_d, 32'd0);
    check("rstjrd_mona", {24'd0, dut.mon_a_reg}, 32'd0);
    #10 reset = 1'b0;
    tick();
    #2 check("post_rst_wait", {31'd0, avs_waitrequest}, 32'd0);
    check("post_rst_data", avs_readdata, 32'hDEADBEEF);
    tick();
    avs_read = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtag_ocimem_ctrl.md
JTAG_OCIMEM_CTRL -- requirements
Module: jtag_ocimem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the debug monitor RAM (2^ADDR_W x 32 bits).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port jdo, input, 38, JTAG data word already synchronised into the clk domain.
REQ-005 SHALL have port take_action_ocimem_a, input, 1, one-cycle pulse for an address-load or read command.
REQ-006 SHALL have port take_no_action_ocimem_a, input, 1, one-cycle pulse for a read at the current address.
REQ-007 SHALL have port take_action_ocimem_b, input, 1, one-cycle pulse for a write at the current address.
REQ-008 SHALL have ports avs_address (in, ADDR_W), avs_read (in, 1), avs_write (in, 1), avs_writedata (in, 32), avs_byteenable (in, 4), forming the CPU-side Avalon-MM slave request.
REQ-009 SHALL have ports avs_readdata (out, 32) and avs_waitrequest (out, 1).
REQ-010 SHALL have ports MonDReg (out, 32), monitor_ready (out, 1) and monitor_error (out, 1), returned to the JTAG debug module.

Function
REQ-011 SHALL hold an ADDR_W-bit address register MonAReg and a single-port RAM with synchronous read and 1-cycle latency.
REQ-012 SHALL implement states IDLE, JRD (JTAG read capture) and AVRD (Avalon read capture); each capture state lasts exactly one cycle and then returns to IDLE.
REQ-013 On take_action_ocimem_a: MonAReg <= jdo[ADDR_W+25:26]; if jdo[35]=1, SHALL issue a RAM read at the new address and enter JRD; monitor_ready <= 0.
REQ-014 On take_no_action_ocimem_a: SHALL issue a RAM read at MonAReg and enter JRD; monitor_ready <= 0.
REQ-015 In JRD: MonDReg <= RAM data, MonAReg <= MonAReg+1, monitor_ready <= 1.
REQ-016 On take_action_ocimem_b: SHALL write jdo[34:3] to RAM[MonAReg] with all byte lanes enabled, MonAReg <= MonAReg+1, monitor_ready <= 1 on the next cycle; the state remains IDLE.
REQ-017 MonAReg increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-018 Avalon write SHALL complete in one cycle with avs_waitrequest=0, honouring avs_byteenable, when no JTAG action is present.
REQ-019 Avalon read SHALL assert avs_waitrequest=1 in the issue cycle, enter AVRD, and present avs_readdata with avs_waitrequest=0 in the following cycle.
REQ-020 A JTAG action SHALL win the RAM port over a simultaneous Avalon request; the Avalon request SHALL see avs_waitrequest=1 and be retried.
REQ-021 An Avalon request presented during JRD SHALL see avs_waitrequest=1.
REQ-022 avs_readdata SHALL hold its value until the next Avalon read capture.
REQ-023 A JTAG action arriving while in JRD SHALL set monitor_error=1 and be ignored.
REQ-024 monitor_error SHALL be cleared by take_action_ocimem_a with jdo[25]=1.
REQ-025 Both read and write SHALL never be asserted by the master together; if they are, read SHALL take priority.

Reset
REQ-026 On reset: state=IDLE, MonAReg=0, MonDReg=0, avs_readdata=0, monitor_ready=0, monitor_error=0; avs_waitrequest SHALL be 0 while reset is asserted.
REQ-027 Reset asserted during JRD or AVRD SHALL abort the capture without updating MonDReg, MonAReg or avs_readdata; RAM contents are not reset.

Structure
REQ-028 State encoding, the default ADDR_W and the jdo field bit positions (35, 34:3, ADDR_W+25:26, 25) SHALL reside in the shared package jtag_ocimem_pkg.
REQ-029 The RAM SHALL be a separate sub-module, jtag_ocimem_ram (single port, byte-enable write, registered read).

Verification
REQ-030 Address load: take_action_ocimem_a with jdo[33:26]=0x10 and jdo[35]=0 -> MonAReg=0x10, no RAM read, monitor_ready=0.
REQ-031 JTAG write/read-back: write 0xDEADBEEF via take_action_ocimem_b at 0x10, reload 0x10 with jdo[35]=1 -> one cycle later MonDReg=0xDEADBEEF, MonAReg=0x11, monitor_ready=1.
REQ-032 Wrap: read at 0xFF -> MonAReg=0x00 after JRD.
REQ-033 Contention: avs_read at 0x20 in the same cycle as take_action_ocimem_b -> avs_waitrequest=1 that cycle; the read completes two cycles later with the correct data.
REQ-034 Overrun: take_no_action_ocimem_a in the cycle after a read issue -> monitor_error=1; a later take_action_ocimem_a with jdo[25]=1 -> monitor_error=0.
REQ-035 Byte write: avs_write of 0x11223344 with avs_byteenable=4'b0010 over 0xFFFFFFFF -> a subsequent read returns 0xFFFF33FF.
